// File: rtl/dds_pkg.sv
// Shared types and constants for the DDS frequency-sweep control path.
package dds_pkg;

  localparam int FTW_W = 32;
  localparam int DWELL_W = 16;
  localparam logic [FTW_W-1:0] DEFAULT_FTW = 32'h07AE_147A;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  typedef struct packed {
    logic [FTW_W-1:0]   start;
    logic [FTW_W-1:0]   stop;
    logic [FTW_W-1:0]   step;
    logic [DWELL_W-1:0] dwell;
    logic               cont;
  } sweep_cfg_t;

endpackage

// File: rtl/dds_sweep_ctrl.sv
// Sweep scheduler: steps the DDS tuning word from start to stop, holding each
// value for dwell+1 cycles, with one-shot or continuous (wrapping) operation.
module dds_sweep_ctrl #(
  parameter int FTW_W   = 32,
  parameter int DWELL_W = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               cfg_valid,
  output logic               cfg_ready,
  input  logic [FTW_W-1:0]   cfg_start,
  input  logic [FTW_W-1:0]   cfg_stop,
  input  logic [FTW_W-1:0]   cfg_step,
  input  logic [DWELL_W-1:0] cfg_dwell,
  input  logic               cfg_cont,
  input  logic               go,
  input  logic               abort,
  output logic [FTW_W-1:0]   ftw,
  output logic               ftw_upd,
  output logic               acc_clr,
  output logic               busy,
  output logic               done
);
  import dds_pkg::state_t;
  import dds_pkg::sweep_cfg_t;
  import dds_pkg::IDLE;
  import dds_pkg::RUN;
  import dds_pkg::DONE;
  import dds_pkg::DEFAULT_FTW;

  state_t             state;
  sweep_cfg_t         cfg_r;
  sweep_cfg_t         cfg_in;
  sweep_cfg_t         cfg_go;
  logic               cfg_loaded;
  logic [DWELL_W-1:0] cnt;
  logic               hs;
  logic [FTW_W:0]     nxt;
  logic               nxt_ok;

  // The carry bit catches a step that would wrap the accumulator word.
  function automatic logic in_range(input logic [FTW_W:0] val,
                                    input logic [FTW_W-1:0] lim);
    return ~val[FTW_W] & (val[FTW_W-1:0] <= lim);
  endfunction

  always_comb begin
    cfg_in       = '0;
    cfg_in.start = cfg_start;
    cfg_in.stop  = cfg_stop;
    cfg_in.step  = cfg_step;
    cfg_in.dwell = cfg_dwell;
    cfg_in.cont  = cfg_cont;
  end

  assign hs     = cfg_valid & cfg_ready;
  assign cfg_go = hs ? cfg_in : cfg_r;
  assign nxt    = {1'b0, ftw} + {1'b0, cfg_r.step};
  assign nxt_ok = in_range(nxt, cfg_r.stop);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      cfg_r      <= '0;
      cfg_loaded <= 1'b0;
      cnt        <= '0;
      ftw        <= DEFAULT_FTW;
      ftw_upd    <= 1'b0;
      acc_clr    <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      cfg_ready  <= 1'b1;
    end else begin
      ftw_upd <= 1'b0;
      acc_clr <= 1'b0;
      done    <= 1'b0;
      case (state)
        IDLE: begin
          if (hs) begin
            cfg_r      <= cfg_in;
            cfg_loaded <= 1'b1;
          end
          // A config offered alongside go is used by this very sweep.
          if (go && (cfg_loaded || hs)) begin
            state     <= RUN;
            ftw       <= cfg_go.start;
            cnt       <= cfg_go.dwell;
            ftw_upd   <= 1'b1;
            acc_clr   <= 1'b1;
            busy      <= 1'b1;
            cfg_ready <= 1'b0;
          end
        end
        RUN: begin
          if (abort) begin
            state     <= IDLE;
            busy      <= 1'b0;
            cfg_ready <= 1'b1;
          end else if (cnt != '0) begin
            cnt <= cnt - 1'b1;
          end else if (cfg_r.step != '0) begin
            if (nxt_ok) begin
              ftw     <= nxt[FTW_W-1:0];
              cnt     <= cfg_r.dwell;
              ftw_upd <= 1'b1;
            end else if (cfg_r.cont) begin
              ftw     <= cfg_r.start;
              cnt     <= cfg_r.dwell;
              ftw_upd <= 1'b1;
            end else begin
              state <= DONE;
              busy  <= 1'b0;
              done  <= 1'b1;
            end
          end
        end
        DONE: begin
          state     <= IDLE;
          cfg_ready <= 1'b1;
        end
        default: begin
          state     <= IDLE;
          busy      <= 1'b0;
          cfg_ready <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dds_sweep_ctrl.sv
// Directed bench for dds_sweep_ctrl: a per-cycle vector table for the one-shot
// sweep plus hand-written sequences for continuous, overflow and handshake cases.
module tb_dds_sweep_ctrl;
  localparam logic [31:0] DEF = 32'h07AE_147A;

  logic        clk = 1'b0;
  logic        rst;
  logic        cfg_valid, cfg_ready, cfg_cont, go, abort;
  logic [31:0] cfg_start, cfg_stop, cfg_step;
  logic [15:0] cfg_dwell;
  logic [31:0] ftw;
  logic        ftw_upd, acc_clr, busy, done;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic        cv, go, ab;
    logic [31:0] ftw;
    logic        upd, clr, busy, done, rdy;
  } vec_t;
  vec_t vecs[$];

  dds_sweep_ctrl #(.FTW_W(32), .DWELL_W(16)) dut (
    .clk(clk), .rst(rst),
    .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .cfg_start(cfg_start), .cfg_stop(cfg_stop), .cfg_step(cfg_step),
    .cfg_dwell(cfg_dwell), .cfg_cont(cfg_cont),
    .go(go), .abort(abort),
    .ftw(ftw), .ftw_upd(ftw_upd), .acc_clr(acc_clr), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic chk_out(input string tag, input logic [31:0] e_ftw, input logic e_upd,
                         input logic e_clr, input logic e_busy, input logic e_done,
                         input logic e_rdy);
    chk({tag, ".ftw"}, ftw, e_ftw);
    chk({tag, ".ftw_upd"}, {31'd0, ftw_upd}, {31'd0, e_upd});
    chk({tag, ".acc_clr"}, {31'd0, acc_clr}, {31'd0, e_clr});
    chk({tag, ".busy"}, {31'd0, busy}, {31'd0, e_busy});
    chk({tag, ".done"}, {31'd0, done}, {31'd0, e_done});
    chk({tag, ".cfg_ready"}, {31'd0, cfg_ready}, {31'd0, e_rdy});
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic add_vec(input logic cv, input logic g, input logic ab, input logic [31:0] f,
                         input logic u, input logic c, input logic b, input logic d,
                         input logic r);
    vec_t v;
    v.cv = cv; v.go = g; v.ab = ab; v.ftw = f;
    v.upd = u; v.clr = c; v.busy = b; v.done = d; v.rdy = r;
    vecs.push_back(v);
  endtask

  task automatic set_cfg(input logic [31:0] s, input logic [31:0] e, input logic [31:0] st,
                         input logic [15:0] dw, input logic ct);
    cfg_start = s; cfg_stop = e; cfg_step = st; cfg_dwell = dw; cfg_cont = ct;
  endtask

  initial begin
    // One-shot 100..250 step 50, dwell 3: handshake, go, 4x4 cycles, done, idle.
    add_vec(1, 0, 0, DEF, 0, 0, 0, 0, 1);
    for (int k = 0; k < 4; k++)
      for (int d = 0; d < 4; d++)
        add_vec(0, (k == 0 && d == 0), 0, 32'(100 + 50 * k), (d == 0),
                (k == 0 && d == 0), 1, 0, 0);
    add_vec(0, 0, 0, 32'd250, 0, 0, 0, 1, 0);
    add_vec(0, 0, 0, 32'd250, 0, 0, 0, 0, 1);

    rst = 1'b1; cfg_valid = 0; go = 0; abort = 0;
    set_cfg(0, 0, 0, 0, 0);
    repeat (2) @(posedge clk);
    #1;
    chk_out("reset", DEF, 0, 0, 0, 0, 1);
    rst = 1'b0;

    go = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cyc();
      chk_out("go_no_cfg", DEF, 0, 0, 0, 0, 1);
    end
    go = 1'b0;

    set_cfg(100, 250, 50, 3, 0);
    foreach (vecs[i]) begin
      cfg_valid = vecs[i].cv; go = vecs[i].go; abort = vecs[i].ab;
      cyc();
      chk_out($sformatf("oneshot[%0d]", i), vecs[i].ftw, vecs[i].upd, vecs[i].clr,
              vecs[i].busy, vecs[i].done, vecs[i].rdy);
    end
    cfg_valid = 0; go = 0; abort = 0;

    // Continuous: three full periods, abort coinciding with a wrap step.
    set_cfg(100, 250, 50, 3, 1);
    cfg_valid = 1'b1;
    cyc();
    cfg_valid = 1'b0;
    go = 1'b1;
    for (int c = 0; c < 48; c++) begin
      cyc();
      go = 1'b0;
      chk_out($sformatf("cont[%0d]", c), 32'(100 + 50 * ((c / 4) % 4)), (c % 4 == 0),
              (c == 0), 1, 0, 0);
    end
    abort = 1'b1;
    cyc();
    abort = 1'b0;
    chk_out("cont_abort", 32'd250, 0, 0, 0, 0, 1);
    cyc();
    chk_out("cont_after_abort", 32'd250, 0, 0, 0, 0, 1);

    // Overflow: next step carries out of 32 bits, so the sweep ends at once.
    set_cfg(32'hFFFF_FF00, 32'hFFFF_FFFF, 32'h200, 0, 0);
    cfg_valid = 1'b1;
    cyc();
    cfg_valid = 1'b0;
    go = 1'b1;
    cyc();
    go = 1'b0;
    chk_out("ovf_first", 32'hFFFF_FF00, 1, 1, 1, 0, 0);
    cyc();
    chk_out("ovf_done", 32'hFFFF_FF00, 0, 0, 0, 1, 0);
    cyc();
    chk_out("ovf_idle", 32'hFFFF_FF00, 0, 0, 0, 0, 1);

    // Config and go together, step 0 hold, config offered while running.
    set_cfg(500, 1000, 0, 2, 0);
    cfg_valid = 1'b1; go = 1'b1;
    cyc();
    cfg_valid = 1'b0; go = 1'b0;
    chk_out("cfg_go_same", 32'd500, 1, 1, 1, 0, 0);
    cfg_start = 32'd7777;
    cfg_valid = 1'b1;
    for (int i = 0; i < 9; i++) begin
      cyc();
      chk_out($sformatf("step0[%0d]", i), 32'd500, 0, 0, 1, 0, 0);
    end
    cfg_valid = 1'b0;
    abort = 1'b1;
    cyc();
    abort = 1'b0;
    chk_out("step0_abort", 32'd500, 0, 0, 0, 0, 1);
    go = 1'b1;
    cyc();
    go = 1'b0;
    chk_out("rego_latched", 32'd500, 1, 1, 1, 0, 0);
    repeat (4) cyc();
    chk_out("rego_hold", 32'd500, 0, 0, 1, 0, 0);

    // Asynchronous reset between edges.
    @(posedge clk);
    #3 rst = 1'b1;
    #1;
    chk_out("async_rst", DEF, 0, 0, 0, 0, 1);
    @(negedge clk);
    rst = 1'b0;
    go = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cyc();
      chk_out("go_after_rst", DEF, 0, 0, 0, 0, 1);
    end
    go = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
